// File: rtl/cursor_key_ctrl_if.sv
// Front-panel key inputs and display-stage outputs of the cursor/zoom controller.
// The panel side (master) drives the raw active-low keys; the controller (slave) drives the rest.
interface cursor_key_ctrl_if;
  logic [1:0]  size_cg;
  logic        cs_cursor;
  logic        move_cursor;
  logic [1:0]  move_h;
  logic [1:0]  move_v;
  logic [1:0]  cs_sel;
  logic [11:0] cursor_u;
  logic [11:0] cursor_d;
  logic [11:0] cursor_l;
  logic [11:0] cursor_r;
  logic [9:0]  diff_t;
  logic [9:0]  diff_v;

  modport master (
    output size_cg, cs_cursor, move_cursor,
    input  move_h, move_v, cs_sel, cursor_u, cursor_d, cursor_l, cursor_r, diff_t, diff_v
  );

  modport slave (
    input  size_cg, cs_cursor, move_cursor,
    output move_h, move_v, cs_sel, cursor_u, cursor_d, cursor_l, cursor_r, diff_t, diff_v
  );
endinterface

// File: rtl/cursor_key_ctrl.sv
// Debounces the four front-panel keys and maintains zoom shifts, cursor selection and positions.
// Define CURSOR_CLAMP_EN to saturate cursors at the screen edge instead of wrapping to the origin.
module cursor_key_ctrl #(
  parameter int unsigned DEB_CNT = 200,
  parameter int unsigned REP_CNT = 500,
  parameter int unsigned BORDER  = 44,
  parameter int unsigned SCREEN  = 512,
  parameter int unsigned UNIT    = 64
) (
  input  logic             clk_10k,
  input  logic             rst_n_wave,
  cursor_key_ctrl_if.slave bus
);

  localparam int unsigned DW = $clog2(DEB_CNT);
  localparam int unsigned RW = $clog2(REP_CNT);
  localparam logic [11:0] POS_MIN = 12'(BORDER);
  localparam logic [11:0] POS_MAX = 12'(BORDER + SCREEN - 1);
  localparam logic [11:0] POS_LO  = 12'(BORDER + 2 * UNIT);
  localparam logic [11:0] POS_HI  = 12'(BORDER + 6 * UNIT);
  localparam int K_V  = 0;
  localparam int K_H  = 1;
  localparam int K_CS = 2;
  localparam int K_MV = 3;

  typedef enum logic {REL = 1'b0, PRS = 1'b1} key_state_e;

  logic [3:0]    raw_s, sync1_q, sync2_q;
  key_state_e    state_q [4];
  key_state_e    state_d [4];
  logic [DW-1:0] deb_cnt_q [4];
  logic [DW-1:0] deb_cnt_d [4];
  logic [3:0]    press_d, press_q;
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          step_s;
  logic [1:0]    move_h_q, move_h_d, move_v_q, move_v_d, cs_sel_q, cs_sel_d;
  logic [11:0]   cur_q [4];
  logic [11:0]   cur_d [4];
  logic [9:0]    diff_t_q, diff_t_d, diff_v_q, diff_v_d;

  function automatic logic [11:0] next_pos(input logic [11:0] pos);
`ifdef CURSOR_CLAMP_EN
    next_pos = (pos >= POS_MAX) ? POS_MAX : pos + 12'd1;
`else
    next_pos = (pos >= POS_MAX) ? POS_MIN : pos + 12'd1;
`endif
  endfunction

  function automatic logic [9:0] abs_diff(input logic [11:0] a, input logic [11:0] b);
    abs_diff = (a > b) ? 10'(a - b) : 10'(b - a);
  endfunction

  assign raw_s = {bus.move_cursor, bus.cs_cursor, bus.size_cg[1], bus.size_cg[0]};

  // Two-flop synchronizers; released level is 1.
  always_ff @(posedge clk_10k or negedge rst_n_wave) begin
    if (!rst_n_wave) begin
      sync1_q <= 4'b1111;
      sync2_q <= 4'b1111;
    end else begin
      sync1_q <= raw_s;
      sync2_q <= sync1_q;
    end
  end

  // Per-key debounce FSM: a level change is accepted after DEB_CNT consecutive mismatch cycles.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      state_d[k]   = state_q[k];
      deb_cnt_d[k] = '0;
      press_d[k]   = 1'b0;
      case (state_q[k])
        REL: begin
          if (!sync2_q[k]) begin
            if (deb_cnt_q[k] == DW'(DEB_CNT - 1)) begin
              state_d[k] = PRS;
              press_d[k] = 1'b1;
            end else begin
              deb_cnt_d[k] = deb_cnt_q[k] + DW'(1);
            end
          end else begin
            deb_cnt_d[k] = '0;
          end
        end
        PRS: begin
          if (sync2_q[k]) begin
            if (deb_cnt_q[k] == DW'(DEB_CNT - 1)) begin
              state_d[k] = REL;
            end else begin
              deb_cnt_d[k] = deb_cnt_q[k] + DW'(1);
            end
          end else begin
            deb_cnt_d[k] = '0;
          end
        end
        default: state_d[k] = REL;
      endcase
    end
  end

  // Debounce state, counters and registered press pulses.
  always_ff @(posedge clk_10k or negedge rst_n_wave) begin
    if (!rst_n_wave) begin
      for (int k = 0; k < 4; k++) begin
        state_q[k]   <= REL;
        deb_cnt_q[k] <= '0;
      end
      press_q <= 4'b0000;
    end else begin
      for (int k = 0; k < 4; k++) begin
        state_q[k]   <= state_d[k];
        deb_cnt_q[k] <= deb_cnt_d[k];
      end
      press_q <= press_d;
    end
  end

  // Auto-repeat starts counting the cycle after the press step, so repeats sit REP_CNT apart.
  always_comb begin
    rep_cnt_d = '0;
    step_s    = press_q[K_MV];
    if ((state_q[K_MV] == PRS) && !press_q[K_MV]) begin
      if (rep_cnt_q == RW'(REP_CNT - 1)) begin
        rep_cnt_d = '0;
        step_s    = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + RW'(1);
      end
    end else begin
      rep_cnt_d = '0;
    end
  end

  // Zoom, selection and cursor next-state; a step uses the selection held before this cycle.
  always_comb begin
    move_h_d = move_h_q;
    move_v_d = move_v_q;
    cs_sel_d = cs_sel_q;
    for (int k = 0; k < 4; k++) begin
      cur_d[k] = cur_q[k];
    end
    if (press_q[K_H]) begin
      move_h_d = (move_h_q == 2'd2) ? 2'd0 : move_h_q + 2'd1;
    end else begin
      move_h_d = move_h_q;
    end
    if (press_q[K_V]) begin
      move_v_d = (move_v_q == 2'd2) ? 2'd0 : move_v_q + 2'd1;
    end else begin
      move_v_d = move_v_q;
    end
    if (press_q[K_CS]) begin
      cs_sel_d = cs_sel_q + 2'd1;
    end else begin
      cs_sel_d = cs_sel_q;
    end
    if (step_s) begin
      cur_d[cs_sel_q] = next_pos(cur_q[cs_sel_q]);
    end else begin
      cur_d[cs_sel_q] = cur_q[cs_sel_q];
    end
    diff_t_d = abs_diff(cur_q[0], cur_q[1]);
    diff_v_d = abs_diff(cur_q[2], cur_q[3]);
  end

  // Output registers.
  always_ff @(posedge clk_10k or negedge rst_n_wave) begin
    if (!rst_n_wave) begin
      rep_cnt_q <= '0;
      move_h_q  <= 2'd0;
      move_v_q  <= 2'd0;
      cs_sel_q  <= 2'd0;
      cur_q[0]  <= POS_LO;
      cur_q[1]  <= POS_HI;
      cur_q[2]  <= POS_LO;
      cur_q[3]  <= POS_HI;
      diff_t_q  <= 10'(POS_HI - POS_LO);
      diff_v_q  <= 10'(POS_HI - POS_LO);
    end else begin
      rep_cnt_q <= rep_cnt_d;
      move_h_q  <= move_h_d;
      move_v_q  <= move_v_d;
      cs_sel_q  <= cs_sel_d;
      for (int k = 0; k < 4; k++) begin
        cur_q[k] <= cur_d[k];
      end
      diff_t_q  <= diff_t_d;
      diff_v_q  <= diff_v_d;
    end
  end

  assign bus.move_h   = move_h_q;
  assign bus.move_v   = move_v_q;
  assign bus.cs_sel   = cs_sel_q;
  assign bus.cursor_u = cur_q[0];
  assign bus.cursor_d = cur_q[1];
  assign bus.cursor_l = cur_q[2];
  assign bus.cursor_r = cur_q[3];
  assign bus.diff_t   = diff_t_q;
  assign bus.diff_v   = diff_v_q;

endmodule

// File: tb/tb_cursor_key_ctrl.sv
// Directed sequence with randomized key hold lengths, checked against a press/step counting model.
module tb_cursor_key_ctrl;

  logic clk_10k = 1'b0;
  logic rst_n_wave;
  int   checks = 0;
  int   errors = 0;

  int m_h, m_v, m_sel;
  int m_cur [4];

  always #50 clk_10k = ~clk_10k;

  cursor_key_ctrl_if bus ();

  cursor_key_ctrl dut (
    .clk_10k   (clk_10k),
    .rst_n_wave(rst_n_wave),
    .bus       (bus)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk_10k);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  // Screen range is [44, 555]; step past the edge wraps or saturates.
  function automatic int step_pos(input int p);
`ifdef CURSOR_CLAMP_EN
    return (p >= 555) ? 555 : p + 1;
`else
    return ((p - 44 + 1) % 512) + 44;
`endif
  endfunction

  // Debounced level is low from ~202 cycles after the raw press until ~202 after release;
  // the first step lands at 203 and the rest every 500 cycles while still held.
  function automatic int count_steps(input int len);
    int n = 0;
    for (int t = 203; t < len + 202; t += 500) n++;
    return n;
  endfunction

  task automatic set_key(input int k, input logic v);
    case (k)
      0:       bus.size_cg[0]  = v;
      1:       bus.size_cg[1]  = v;
      2:       bus.cs_cursor   = v;
      default: bus.move_cursor = v;
    endcase
  endtask

  task automatic hold_key(input int k, input int len);
    set_key(k, 1'b0);
    tick(len);
    set_key(k, 1'b1);
    tick(300);
  endtask

  task automatic reset_model();
    m_h = 0; m_v = 0; m_sel = 0;
    m_cur[0] = 172; m_cur[1] = 428; m_cur[2] = 172; m_cur[3] = 428;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".move_h"},   bus.move_h,   m_h);
    check({tag, ".move_v"},   bus.move_v,   m_v);
    check({tag, ".cs_sel"},   bus.cs_sel,   m_sel);
    check({tag, ".cursor_u"}, bus.cursor_u, m_cur[0]);
    check({tag, ".cursor_d"}, bus.cursor_d, m_cur[1]);
    check({tag, ".cursor_l"}, bus.cursor_l, m_cur[2]);
    check({tag, ".cursor_r"}, bus.cursor_r, m_cur[3]);
    check({tag, ".diff_t"},   bus.diff_t,   absd(m_cur[0], m_cur[1]));
    check({tag, ".diff_v"},   bus.diff_v,   absd(m_cur[2], m_cur[3]));
  endtask

  initial begin
    int len, n0, nv;

    rst_n_wave      = 1'b0;
    bus.size_cg     = 2'b11;
    bus.cs_cursor   = 1'b1;
    bus.move_cursor = 1'b1;
    reset_model();
    tick(3);
    check_all("reset");
    rst_n_wave = 1'b1;
    tick(10000);
    check_all("idle");

    // Short glitch is filtered out.
    hold_key(1, 150);
    check("h_glitch", bus.move_h, 0);

    // Accepted press latency.
    set_key(1, 1'b0);
    tick(198);
    check("h_before_accept", bus.move_h, 0);
    tick(8);
    check("h_after_accept", bus.move_h, 1);
    tick(94);
    set_key(1, 1'b1);
    tick(300);
    m_h = 1;
    for (int i = 0; i < 2; i++) begin
      hold_key(1, $urandom_range(400, 250));
      m_h = (m_h + 1) % 3;
      check("h_cycle", bus.move_h, m_h);
    end
    nv = $urandom_range(2, 1);
    for (int i = 0; i < nv; i++) begin
      hold_key(0, $urandom_range(400, 250));
      m_v = (m_v + 1) % 3;
    end
    check_all("zoom");

    // Auto-repeat on cursor U.
    set_key(3, 1'b0);
    tick(198);
    check("u_before_step", bus.cursor_u, 172);
    tick(8);
    check("u_step1", bus.cursor_u, 173);
    check("dt_step1", bus.diff_t, absd(173, 428));
    tick(494);
    check("u_before_rep", bus.cursor_u, 173);
    tick(6);
    check("u_step2", bus.cursor_u, 174);
    tick(500);
    check("u_step3", bus.cursor_u, 175);
    tick(94);
    set_key(3, 1'b1);
    tick(300);
    m_cur[0] = 175;
    check_all("move_u");

    // Select L and move it only.
    for (int i = 0; i < 2; i++) begin
      hold_key(2, $urandom_range(400, 250));
      m_sel = (m_sel + 1) % 4;
    end
    check("sel_l", bus.cs_sel, 2);
    n0  = $urandom_range(1, 0);
    len = 250 + 500 * n0 + $urandom_range(200, 0);
    hold_key(3, len);
    for (int i = 0; i < count_steps(len); i++) m_cur[m_sel] = step_pos(m_cur[m_sel]);
    check_all("move_l");

    // Walk R to the screen edge and one step beyond.
    hold_key(2, $urandom_range(400, 250));
    m_sel = 3;
    set_key(3, 1'b0);
    tick(203 + 500 * 126 + 250);
    check("r_at_edge", bus.cursor_r, 555);
    tick(300);
    check("r_past_edge", bus.cursor_r, step_pos(555));
    set_key(3, 1'b1);
    tick(300);
    m_cur[3] = step_pos(555);
    check_all("edge");

    // Asynchronous reset in the middle of auto-repeat.
    set_key(3, 1'b0);
    tick(800);
    rst_n_wave = 1'b0;
    #1;
    reset_model();
    check_all("async_rst");
    set_key(3, 1'b1);
    tick(3);
    rst_n_wave = 1'b1;
    tick(1000);
    check_all("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
